muldiv_sequencer: RTL and testbench

- Control FSM that sequences the iterative multiply/divide unit for the multicycle CPU.
- Accepts mult/div commands from main control and latches the operands so they stay stable while the unit iterates.
- Clears the unit, drives its 2-bit mode select, counts iterations and commits the result into the architectural Hi/Lo registers.
- Stalls main control while busy and raises a divide-by-zero exception without running the unit.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter_counter.sv | 53 +++++
 rtl/muldiv_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//
// Shared definitions for the multiply/divide sequencer:
//   state_e  - sequencer FSM states
//   op_e     - unit mode-select / latched operation encodings
//   *_DEF    - default iteration counts and counter width
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    COMMIT = 3'd3,
    EXC    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MULT = 2'b01,
    OP_DIV  = 2'b10
  } op_e;

  // Booth multiply retires one bit per cycle; restoring divide needs one extra
  // step to produce the final remainder.
  localparam int MULT_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF  = 33;
  localparam int CNT_W_DEF       = 6;

endpackage : muldiv_pkg

// File: rtl/muldiv_iter_counter.sv
// -----------------------------------------------------------------------------
// muldiv_iter_counter
//
// Loadable iteration counter with a terminal-count compare.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset (count -> 0)
//   clear  in   synchronous clear to 0 (has priority over inc)
//   inc    in   increment by one this cycle
//   limit  in   terminal value (last iteration index, i.e. cycles-1)
//   tc     out  count currently equals limit
// -----------------------------------------------------------------------------
module muldiv_iter_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Compare against the current value: tc is high during the last iteration,
  // so the FSM leaves RUN at the edge that ends it.
  assign tc = (cnt_q == limit);

endmodule : muldiv_iter_counter

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Control FSM for the iterative multiply/divide unit of the multicycle CPU.
// Accepts mult/div commands, latches the operands for the unit, clears the
// unit, drives its mode select for the required number of iterations and
// commits the unit's Hi/Lo into the architectural Hi/Lo registers. A divide
// by zero raises a one-cycle exception pulse without running the unit.
//
// Configuration macro:
//   MULDIV_EARLY_EXIT_EN - when defined, a mult with a zero operand skips
//                          CLEAR/RUN and commits Hi = Lo = 0 one cycle after
//                          accept. Undefined: every mult runs all iterations.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   op_valid, op_code  command request (01 mult, 10 div, others ignored)
//   op_a, op_b         operands (rs, rt), passed to the unit unchanged
//   hilo_rd            main control wants to read Hi/Lo
//   md_a, md_b         latched operands to the unit
//   md_ctrl            unit mode select: 00 idle, 01 mult, 10 div
//   md_reset           unit clear (high in CLEAR and while reset is high)
//   md_hi, md_lo       unit results
//   busy               operation in flight (CLEAR, RUN, COMMIT, EXC)
//   stall              busy & (op_valid | hilo_rd), combinational
//   done               one-cycle pulse during COMMIT
//   div_zero_exc       one-cycle pulse on division by zero
//   hi_q, lo_q         architectural Hi/Lo
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hilo_rd,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [1:0]  md_ctrl,
  output logic        md_reset,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero_exc,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  // Last iteration index for each operation.
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  state_e      state_d, state_q;
  op_e         op_d, op_q;
  logic [31:0] md_a_d, md_a_q;
  logic [31:0] md_b_d, md_b_q;
  logic [1:0]  md_ctrl_d, md_ctrl_q;
  logic        md_reset_d, md_reset_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        exc_d, exc_q;
  logic [31:0] hi_d, lo_d;
  logic [31:0] hi_r, lo_r;

  logic        cnt_clear;
  logic        cnt_inc;
  logic        cnt_tc;
  logic [CNT_W-1:0] cnt_limit;

  // ---------------------------------------------------------------------------
  // Iteration counter: zeroed during CLEAR, advanced every RUN cycle.
  // ---------------------------------------------------------------------------
  assign cnt_clear = (state_q == CLEAR);
  assign cnt_inc   = (state_q == RUN);
  assign cnt_limit = (op_q == OP_DIV) ? DIV_LAST : MULT_LAST;

  muldiv_iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .tc    (cnt_tc)
  );

  // ---------------------------------------------------------------------------
  // Next-state and datapath-register logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    md_a_d  = md_a_q;
    md_b_d  = md_b_q;
    hi_d    = hi_r;
    lo_d    = lo_r;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          if ((op_code == OP_MULT) || ((op_code == OP_DIV) && (op_b != '0))) begin
            md_a_d  = op_a;
            md_b_d  = op_b;
            op_d    = op_e'(op_code);
            state_d = CLEAR;
`ifdef MULDIV_EARLY_EXIT_EN
            // A zero operand makes the product zero: skip the unit entirely.
            // OP_NONE in COMMIT marks a zero-result commit.
            if ((op_code == OP_MULT) && ((op_a == '0) || (op_b == '0))) begin
              op_d    = OP_NONE;
              state_d = COMMIT;
            end
`endif
          end else if (op_code == OP_DIV) begin
            // Divide by zero: operands are not loaded, the unit never runs.
            state_d = EXC;
          end
        end
      end

      CLEAR: state_d = RUN;

      RUN: begin
        if (cnt_tc) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        // The unit's last iteration settled at the edge entering COMMIT, so
        // md_hi/md_lo are final here; intermediate values never get this far.
        hi_d    = (op_q == OP_NONE) ? '0 : md_hi;
        lo_d    = (op_q == OP_NONE) ? '0 : md_lo;
        state_d = IDLE;
      end

      EXC: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered and
  // aligned with the state they describe.
  always_comb begin
    busy_d     = (state_d != IDLE);
    md_reset_d = (state_d == CLEAR);
    md_ctrl_d  = (state_d == RUN) ? op_d : OP_NONE;
    done_d     = (state_d == COMMIT);
    exc_d      = (state_d == EXC);
  end

  // ---------------------------------------------------------------------------
  // State and output registers. md_reset comes out of reset high so the unit
  // is held clear for as long as reset is asserted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_NONE;
      md_a_q     <= '0;
      md_b_q     <= '0;
      md_ctrl_q  <= OP_NONE;
      md_reset_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      exc_q      <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      md_ctrl_q  <= md_ctrl_d;
      md_reset_q <= md_reset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      exc_q      <= exc_d;
      hi_r       <= hi_d;
      lo_r       <= lo_d;
    end
  end

  assign md_a         = md_a_q;
  assign md_b         = md_b_q;
  assign md_ctrl      = md_ctrl_q;
  assign md_reset     = md_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero_exc = exc_q;
  assign hi_q         = hi_r;
  assign lo_q         = lo_r;

  // Requests arriving while busy are held off; in COMMIT this keeps a pending
  // Hi/Lo read from seeing the pre-commit values.
  assign stall = busy_q & (op_valid | hilo_rd);

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer. A behavioural mult/div unit model
// is attached to the md_* ports; expected results come from plain signed
// arithmetic on the command operands.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        hilo_rd;
  logic [31:0] md_a, md_b;
  logic [1:0]  md_ctrl;
  logic        md_reset;
  logic [31:0] md_hi, md_lo;
  logic        busy, stall, done, div_zero_exc;
  logic [31:0] hi_q, lo_q;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // cycles from accept edge to done/exc; 0 = ignored
    logic [31:0] hi;
    logic [31:0] lo;
    bit          exc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_a         (op_a),
    .op_b         (op_b),
    .hilo_rd      (hilo_rd),
    .md_a         (md_a),
    .md_b         (md_b),
    .md_ctrl      (md_ctrl),
    .md_reset     (md_reset),
    .md_hi        (md_hi),
    .md_lo        (md_lo),
    .busy         (busy),
    .stall        (stall),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .hi_q         (hi_q),
    .lo_q         (lo_q)
  );

  // ---------------------------------------------------------------------------
  // Reference arithmetic.
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return p;
  endfunction

  // Returns {remainder, quotient}, truncating toward zero.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (sb == 0) return 64'd0;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int mult_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return 34;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural iterative unit: needs 32 (mult) / 33 (div) uninterrupted
  // cycles of its mode select after a clear; anything else shows garbage.
  // ---------------------------------------------------------------------------
  int unsigned ucnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ucnt  <= 0;
      md_hi <= 32'hDEAD_BEEF;
      md_lo <= 32'hBAD0_BAD0;
    end else if (md_reset) begin
      ucnt  <= 0;
      md_hi <= $urandom;
      md_lo <= $urandom;
    end else if (md_ctrl != 2'b00) begin
      ucnt <= ucnt + 1;
      if (md_ctrl == 2'b01 && ucnt + 1 == 32)
        {md_hi, md_lo} <= mul_ref(md_a, md_b);
      else if (md_ctrl == 2'b10 && ucnt + 1 == 33)
        {md_hi, md_lo} <= div_ref(md_a, md_b);
      else begin
        md_hi <= $urandom;
        md_lo <= $urandom;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command from the table at #1 after a clock edge (DUT in IDLE)
  // and follows it to completion.
  task automatic run_vec(input vec_t v, input string tag);
    int k = 1;
    int ctrl_cyc = 0;
    int busy_low = 0;
    int activity = 0;
    int exp_ctrl;
    op_valid = 1'b1; op_code = v.op; op_a = v.a; op_b = v.b;
    @(posedge clk); #1;
    // Scramble the inputs after accept: the unit must see the latched copy.
    op_valid = 1'b0; op_code = 2'b00; op_a = $urandom; op_b = $urandom;
    if (v.lat == 0) begin
      for (int c = 0; c < 4; c++) begin
        if (busy || done || div_zero_exc || md_ctrl != 2'b00) activity++;
        @(posedge clk); #1;
      end
      check({tag, "_ignored_activity"}, activity, 0);
      check({tag, "_hi"}, hi_q, v.hi);
      check({tag, "_lo"}, lo_q, v.lo);
      return;
    end
    while (!(done || div_zero_exc) && k < 100) begin
      if (!busy) busy_low++;
      if (md_ctrl == v.op) ctrl_cyc++;
      if (k == 2 && !v.exc && v.lat > 2) begin
        check({tag, "_md_a"}, md_a, v.a);
        check({tag, "_md_b"}, md_b, v.b);
      end
      @(posedge clk); #1; k++;
    end
    if (!busy) busy_low++;
    exp_ctrl = (!v.exc && v.lat > 2) ? v.lat - 2 : 0;
    check({tag, "_latency"}, k, v.lat);
    check({tag, "_done"}, done, !v.exc);
    check({tag, "_exc"}, div_zero_exc, v.exc);
    check({tag, "_busy_cycles_low"}, busy_low, 0);
    check({tag, "_md_ctrl_cycles"}, ctrl_cyc, exp_ctrl);
    check({tag, "_md_ctrl_end"}, md_ctrl, 2'b00);
    @(posedge clk); #1;
    check({tag, "_pulse_width"}, {done, div_zero_exc, busy}, 3'b000);
    check({tag, "_hi"}, hi_q, v.hi);
    check({tag, "_lo"}, lo_q, v.lo);
  endtask

  // Hard bound on the whole run.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] m_hi, m_lo;
    logic [63:0] r, exp_mul, exp_div;
    int k, stall_low, activity;

    // ---------------- vector table ----------------
    vecs.push_back('{2'b01, 32'd7,      32'hFFFF_FFFD, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{2'b10, 32'd100,    32'd7,         35, 32'd2,         32'd14,        1'b0});
    vecs.push_back('{2'b10, 32'h2211,   32'h100,       35, 32'h11,        32'h22,        1'b0});
    vecs.push_back('{2'b10, 32'd5,      32'd0,         1,  32'h11,        32'h22,        1'b1});
    vecs.push_back('{2'b00, 32'd3,      32'd4,         0,  32'h11,        32'h22,        1'b0});
    vecs.push_back('{2'b11, 32'd3,      32'd4,         0,  32'h11,        32'h22,        1'b0});
    vecs.push_back('{2'b01, 32'd0,      32'd9,         mult_lat(32'd0, 32'd9), 32'd0, 32'd0, 1'b0});
    m_hi = 32'd0; m_lo = 32'd0;
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.op  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      v.a   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      v.b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      v.exc = 1'b0;
      if (v.op == 2'b01) begin
        r = mul_ref(v.a, v.b); v.lat = mult_lat(v.a, v.b);
      end else if (v.b == 32'd0) begin
        r = {m_hi, m_lo}; v.lat = 1; v.exc = 1'b1;
      end else begin
        r = div_ref(v.a, v.b); v.lat = 35;
      end
      v.hi = r[63:32]; v.lo = r[31:0];
      m_hi = v.hi; m_lo = v.lo;
      vecs.push_back(v);
    end

    // ---------------- reset state ----------------
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_a = '0; op_b = '0; hilo_rd = 1'b0;
    #1;
    check("rst_hi_lo", {hi_q, lo_q}, 64'd0);
    check("rst_md_ab", {md_a, md_b}, 64'd0);
    check("rst_ctrl", {md_ctrl, md_reset}, 3'b001);
    check("rst_flags", {busy, done, div_zero_exc}, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_md_reset", md_reset, 1'b0);
    hilo_rd = 1'b1;
    @(negedge clk);
    check("idle_read_no_stall", stall, 1'b0);
    hilo_rd = 1'b0;
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ---------------- back-to-back with held div and Hi/Lo read ----------------
    exp_mul = mul_ref(32'h0001_2345, 32'hFFFF_0003);
    exp_div = {32'd6, 32'hFFFF_FF72};   // 1000 / -7 = -142 rem 6
    op_valid = 1'b1; op_code = 2'b01; op_a = 32'h0001_2345; op_b = 32'hFFFF_0003;
    @(posedge clk); #1;
    op_code = 2'b10; op_a = 32'd1000; op_b = 32'hFFFF_FFF9;
    k = 1; stall_low = 0;
    while (!done && k < 100) begin
      if (k == 10) hilo_rd = 1'b1;
      @(negedge clk);
      if (!stall) stall_low++;
      @(posedge clk); #1; k++;
    end
    check("b2b_mult_latency", k, 34);
    @(negedge clk);
    if (!stall) stall_low++;
    check("b2b_stall_low_cycles", stall_low, 0);
    @(posedge clk); #1;
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_read_hi", hi_q, exp_mul[63:32]);
    check("b2b_read_lo", lo_q, exp_mul[31:0]);
    @(negedge clk);
    check("b2b_released_stall", stall, 1'b0);
    hilo_rd = 1'b0;
    @(posedge clk); #1;
    check("b2b_div_accepted", {busy, md_reset}, 2'b11);
    op_valid = 1'b0; op_code = 2'b00;
    k = 1;
    while (!done && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("b2b_div_latency", k, 35);
    @(posedge clk); #1;
    check("b2b_div_hi", hi_q, exp_div[63:32]);
    check("b2b_div_lo", lo_q, exp_div[31:0]);

    // ---------------- reset in the middle of a divide ----------------
    op_valid = 1'b1; op_code = 2'b10; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 2'b00;
    repeat (10) begin @(posedge clk); #1; end   // now in RUN cycle 10
    check("mid_reset_running", md_ctrl, 2'b10);
    reset = 1'b1;
    #1;
    check("mid_reset_hi_lo", {hi_q, lo_q}, 64'd0);
    check("mid_reset_state", {busy, md_ctrl, md_reset}, 4'b0001);
    activity = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || div_zero_exc) activity++;
    end
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || div_zero_exc || busy) activity++;
    end
    check("mid_reset_no_pulse", activity, 0);
    run_vec('{2'b01, 32'd7, 32'd9, 34, 32'd0, 32'd63, 1'b0}, "post_reset_mult");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_muldiv_sequencer
